// File: rtl/ece423_bidir_pio_if.sv
// rtl/ece423_bidir_pio_if.sv - Avalon-MM slave bus and interrupt bundle for ece423_bidir_pio
interface ece423_bidir_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/ece423_bidir_pio.sv
// rtl/ece423_bidir_pio.sv - bidirectional PIO with set/clear writes, synchroniser and edge-capture irq
// Optional open-drain pin drive is enabled by defining ECE423_PIO_OPEN_DRAIN_EN.
module ece423_bidir_pio #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  ece423_bidir_pio_if.slave  bus,
  inout  wire  [WIDTH-1:0]   bidir_port
);
  localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] dout, dir, mask, cap;
  logic [WIDTH-1:0] din_s, din_p, edge_det, wd, w1c;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [2:0]       warm;
  logic             wr, warm_done;
  logic [31:0]      rd_next, readdata_q;
  logic             unused_wd;

  assign wr        = bus.chipselect && !bus.write_n;
  assign wd        = bus.writedata[WIDTH-1:0];
  assign unused_wd = ^bus.writedata;
  assign din_s     = sync_q[SYNC_STAGES-1];
  assign warm_done = (warm == WARM_MAX);
  assign w1c       = (wr && bus.address == 3'd3) ? wd : '0;

  // Edges are ignored until the synchroniser has refilled after reset.
  always_comb begin
    edge_det = '0;
    if (warm_done) begin
      case (EDGE_TYPE)
        0:       edge_det = din_s & ~din_p;
        1:       edge_det = ~din_s & din_p;
        default: edge_det = din_s ^ din_p;
      endcase
    end
  end

  always_comb begin
    rd_next = '0;
    case (bus.address)
      3'd0:    rd_next[WIDTH-1:0] = din_s;
      3'd1:    rd_next[WIDTH-1:0] = dir;
      3'd2:    rd_next[WIDTH-1:0] = mask;
      3'd3:    rd_next[WIDTH-1:0] = cap;
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= RESET_OUT;
      dir        <= RESET_DIR;
      mask       <= '0;
      cap        <= '0;
      sync_q     <= '0;
      din_p      <= '0;
      warm       <= '0;
      readdata_q <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], bidir_port};
      din_p      <= din_s;
      readdata_q <= rd_next;
      if (!warm_done) warm <= warm + 3'd1;
      // A new edge on a bit overrides a simultaneous write-1-to-clear.
      cap <= (cap & ~w1c) | edge_det;
      if (wr) begin
        case (bus.address)
          3'd0:    dout <= wd;
          3'd1:    dir  <= wd;
          3'd2:    mask <= wd;
          3'd4:    dout <= dout | wd;
          3'd5:    dout <= dout & ~wd;
          default: ;
        endcase
      end
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = |(cap & mask);

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
`ifdef ECE423_PIO_OPEN_DRAIN_EN
    assign bidir_port[i] = (dir[i] && !dout[i]) ? 1'b0 : 1'bz;
`else
    assign bidir_port[i] = dir[i] ? dout[i] : 1'bz;
`endif
  end
endmodule

// File: tb/tb_ece423_bidir_pio.sv
// tb/tb_ece423_bidir_pio.sv - scoreboard bench for ece423_bidir_pio
module tb_ece423_bidir_pio;
  localparam int W = 8;
  localparam int S = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ece423_bidir_pio_if bus();
  wire  [W-1:0] pins;
  logic [W-1:0] tb_oe, tb_val;

  for (genvar i = 0; i < W; i++) begin : g_drv
    assign pins[i] = tb_oe[i] ? tb_val[i] : 1'bz;
  end

  ece423_bidir_pio #(
    .WIDTH(W), .RESET_OUT(8'hA5), .RESET_DIR(8'h0F), .EDGE_TYPE(0), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .bidir_port(pins)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick(1);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_rd(input string tag, input logic [2:0] a, input logic [31:0] e);
    bus.address = a;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    tick(1);
    chk(tag_q.pop_front(), bus.readdata, exp_q.pop_front());
  endtask

  initial begin
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    tb_oe  = 8'hF0;
    tb_val = 8'h60;

    tick(3);
    chk("rst_readdata", bus.readdata, 32'h0);
    chk("rst_irq", 32'(bus.irq), 32'h0);
    reset = 1'b0;
    tick(6);

`ifndef ECE423_PIO_OPEN_DRAIN_EN
    bus_rd("rst_data", 3'd0, 32'h65);
    chk("rst_pin_lo", 32'(pins[3:0]), 32'h5);
`endif
    bus_rd("rst_dir", 3'd1, 32'h0F);
    for (int a = 2; a < 8; a++) bus_rd("rst_zero", 3'(a), 32'h0);
    chk("rst_irq2", 32'(bus.irq), 32'h0);

`ifndef ECE423_PIO_OPEN_DRAIN_EN
    tb_oe = 8'h00;
    bus_wr(3'd1, 32'hFF);
    bus_wr(3'd0, 32'h3C);
    bus_wr(3'd4, 32'hFFFF_FF01);
    bus_wr(3'd5, 32'h0C);
    tick(S + 1);
    bus_rd("setclr_data", 3'd0, 32'h31);
    chk("setclr_pins", 32'(pins), 32'h31);
    bus_rd("outset_rd", 3'd4, 32'h0);
    bus_rd("outclr_rd", 3'd5, 32'h0);
`endif

    bus_wr(3'd1, 32'h00);
    tb_val = 8'h00;
    tb_oe  = 8'hFF;
    tick(4);
    bus_wr(3'd3, 32'hFF);
    bus_wr(3'd2, 32'h02);
    bus_rd("cap_clear", 3'd3, 32'h0);
    chk("irq_idle", 32'(bus.irq), 32'h0);

    tb_val[1] = 1'b1;
    tick(S);
    chk("irq_early", 32'(bus.irq), 32'h0);
    tick(1);
    chk("irq_rise", 32'(bus.irq), 32'h1);
    bus_rd("cap_bit1", 3'd3, 32'h02);
    bus_wr(3'd3, 32'h02);
    chk("irq_w1c", 32'(bus.irq), 32'h0);
    bus_rd("cap_w1c", 3'd3, 32'h0);

    tb_val = 8'h20;
    tick(S + 1);
    bus_rd("cap_bit5", 3'd3, 32'h20);
    chk("irq_masked", 32'(bus.irq), 32'h0);
    bus_wr(3'd3, 32'hFF);

    tb_val[1] = 1'b1;
    tick(S);
    bus_wr(3'd3, 32'h02);
    bus_rd("cap_edge_wins", 3'd3, 32'h02);
    chk("irq_edge_wins", 32'(bus.irq), 32'h1);

    tb_oe  = 8'hF0;
    tb_val = 8'hF0;
    reset  = 1'b1;
    tick(1);
    chk("midrst_irq", 32'(bus.irq), 32'h0);
    chk("midrst_readdata", bus.readdata, 32'h0);
    tick(1);
    reset = 1'b0;
    tick(8);
    bus_rd("warm_cap", 3'd3, 32'h0);
    bus_rd("midrst_mask", 3'd2, 32'h0);
    bus_rd("midrst_dir", 3'd1, 32'h0F);
`ifndef ECE423_PIO_OPEN_DRAIN_EN
    bus_rd("midrst_data", 3'd0, 32'hF5);
`endif
    chk("warm_irq", 32'(bus.irq), 32'h0);

`ifdef ECE423_PIO_OPEN_DRAIN_EN
    bus_wr(3'd1, 32'h01);
    tb_oe  = 8'hFE;
    tb_val = 8'h00;
    bus_wr(3'd0, 32'h00);
    tick(S + 1);
    bus_rd("od_low", 3'd0, 32'h00);
    bus_wr(3'd0, 32'h01);
    tb_oe  = 8'hFF;
    tb_val = 8'h01;
    tick(S + 1);
    bus_rd("od_release", 3'd0, 32'h01);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ece423_bidir_pio.md
# ece423_bidir_pio

Parametrised bidirectional parallel I/O port for the ECE423 Qsys system. It is the multi-bit successor to the single-bit SDA/SCL pins and adds:
- per-bit direction;
- atomic set/clear writes;
- a metastability synchroniser;
- edge capture with a maskable interrupt;
- an optional open-drain drive mode for I2C-style buses.

It sits on the Avalon-MM bus as a slave, with `bidir_port` routed to top-level pins.

## Interface
Parameters:
- `WIDTH`, 8: number of pins, 1..32.
- `RESET_OUT`, 0: reset value of the output data register (`WIDTH` bits).
- `RESET_DIR`, 0: reset value of the direction register (1 = drive).
- `EDGE_TYPE`, 0: edge detected; 0 = rising, 1 = falling, 2 = any.
- `SYNC_STAGES`, 2: synchroniser depth, 2..4.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  reset; one clock; reset is synchronous and active-high.
- `address`  in  3  register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data; bits above `WIDTH` ignored.
- `readdata`  out  32  registered read data; bits above `WIDTH` read 0.
- `bidir_port`  inout  `WIDTH`  pins.
- `irq`  out  1  level interrupt.

## Operation
Register map (a write = `chipselect && !write_n`):
- 0 DATA: read returns the synchronised pin value `din_s`; write loads `dout`.
- 1 DIR: read/write `dir`.
- 2 IRQMASK: read/write `mask`.
- 3 EDGECAP: read returns `cap`; write-1-to-clear per bit.
- 4 OUTSET: write `dout |= wd`; read 0.
- 5 OUTCLR: write `dout &= ~wd`; read 0.
- 6, 7: read 0; writes ignored.

Datapath:
- Synchroniser: `SYNC_STAGES` flip-flops per bit. The last stage is `din_s`; `din_p` is `din_s` delayed one cycle.
- Edge detect per `EDGE_TYPE`:
  - rising: `din_s & ~din_p`
  - falling: `~din_s & din_p`
  - any: `din_s ^ din_p`
- A detected edge sets the corresponding `cap` bit.
- `irq = |(cap & mask)`, combinational from registers.
- Warm-up counter: after reset, edge detection is suppressed for `SYNC_STAGES+1` cycles so the pre-filled synchroniser cannot produce false edges. The counter saturates and is then idle.
- Pin drive (push-pull): bit i = `dir[i] ? dout[i] : Z`.

Boundary conditions:
- W1C clear and a new edge on the same bit in the same cycle: the edge wins and `cap` stays 1.
- OUTSET/OUTCLR only touch the written bits; other bits are held.
- Reset asserted mid-operation: on the next edge every register returns to its reset value and the warm-up counter restarts.

Reset values:
- `dout` = `RESET_OUT`, `dir` = `RESET_DIR`.
- `mask`, `cap`, synchroniser, `din_p` = 0.
- `readdata` = 0, `irq` = 0.

## Timing
- Read latency is 1 cycle. `readdata` is registered every cycle from the current `address`, independent of `chipselect`.
- Writes take effect at the clock edge where they are sampled. `bidir_port` reflects a new `dout`/`dir` in the following cycle.
- Pin to DATA: a pin change at edge k appears in `din_s` after edge k+`SYNC_STAGES`-1 and in `readdata` one edge later.
- Pin to `cap`/`irq`: `cap` is set at edge k+`SYNC_STAGES`; `irq` rises combinationally from it in the same cycle.
- After `reset` deasserts, the earliest edge that can be captured is at cycle `SYNC_STAGES`+2.

## Configuration
`ECE423_PIO_OPEN_DRAIN_EN`:
- Defined: bit i drives 0 when `dir[i] && !dout[i]` and is otherwise Z. A pull-up supplies logic 1, which makes the block suitable for SDA/SCL.
- Undefined: push-pull drive as described in Operation.
- Register map and reads are identical in both builds.

## Test plan
- Reset, then read addresses 0–7 with `RESET_OUT`=8'hA5, `RESET_DIR`=8'h0F:
  - address 0 = pin value;
  - address 1 = 0x0F;
  - all other addresses = 0;
  - `irq` = 0;
  - pins 3:0 drive 4'h5, pins 7:4 are Z.
- Write DATA=0x3C, then OUTSET=0x01, then OUTCLR=0x0C:
  - DATA internal `dout` = 0x31;
  - with DIR=0xFF, pins read back 0x31 after `SYNC_STAGES`+1 cycles.
- `EDGE_TYPE`=0, mask=0x02, pin1 toggled 0→1:
  - `cap` = 0x02 at edge k+`SYNC_STAGES`;
  - `irq` = 1;
  - W1C 0x02 clears both `cap` and `irq`.
- Pin1 rising edge detected in the same cycle as a W1C of 0x02: `cap[1]` remains 1.
- Hold all pins high through reset, then release: `cap` stays 0x00 (warm-up suppression).
- `ECE423_PIO_OPEN_DRAIN_EN` defined, DIR=0x01:
  - DATA=0x00 gives pin0 = 0;
  - DATA=0x01 gives pin0 = Z.
